// File: rtl/shift_reg_sipo.sv
// Serial-in, parallel-out deserializer with sync framing, a one-word holding register
// on a valid/ready output, and a sticky overrun flag for dropped words.
module shift_reg_sipo #(
  parameter int size      = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            datain,
  input  logic            shift_en,
  input  logic            sync,
  output logic [size-1:0] dataout,
  output logic            dataout_valid,
  input  logic            dataout_ready,
  output logic            overrun,
  input  logic            clear_overrun
);
  localparam int CW = $clog2(size + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  logic [size-1:0] sr;
  logic [CW-1:0]   count;
  logic [size-1:0] sr_base;
  logic [size-1:0] sr_next;
  logic            last_bit;
  logic            consume;

  // A sync bit starts from an empty register so partial-word residue never leaks in.
  assign sr_base  = sync ? '0 : sr;
  assign sr_next  = MSB_FIRST ? {sr_base[size-2:0], datain} : {datain, sr_base[size-1:1]};
  assign last_bit = (count == CW'(size - 1));
  assign consume  = dataout_valid && dataout_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      sr            <= '0;
      count         <= '0;
      dataout       <= '0;
      dataout_valid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (clear_overrun) overrun <= 1'b0;
      if (consume) dataout_valid <= 1'b0;
      if (shift_en) begin
        if (sync) begin
          state <= SHIFT;
          sr    <= sr_next;
          count <= CW'(1);
        end else if (state == SHIFT) begin
          if (last_bit) begin
            sr    <= '0;
            count <= '0;
            // Holding register is free if empty or being drained on this same edge.
            if (!dataout_valid || dataout_ready) begin
              dataout       <= sr_next;
              dataout_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            sr    <= sr_next;
            count <= count + CW'(1);
          end
        end
      end
    end
  end
endmodule
